// File: rtl/rns_pkg.sv
// Shared RNS constants: digit width, digit count, the eight pairwise-coprime
// moduli used by the accumulator, normalizer and MRC stages, and common typedefs.
package rns_pkg;

    localparam int RNS_DIG_W   = 18;
    localparam int RNS_NUM_DIG = 8;

    // Eight distinct primes just below 2^18, hence pairwise coprime.
    localparam logic [RNS_DIG_W-1:0] RNS_MOD [RNS_NUM_DIG] = '{
        18'd262139, 18'd262133, 18'd262127, 18'd262121,
        18'd262111, 18'd262109, 18'd262103, 18'd262079
    };

    typedef logic [RNS_DIG_W-1:0]          rns_dig_t;
    typedef rns_dig_t [RNS_NUM_DIG-1:0]    rns_vec_t;

    typedef enum logic {
        ACC_EMPTY = 1'b0,
        ACC_ACCUM = 1'b1
    } acc_state_t;

endpackage

// File: rtl/rns_mod_add.sv
// Combinational modular adder for one residue digit: (a + b) mod MOD,
// valid whenever both operands are already below MOD.
module rns_mod_add #(
    parameter int             W   = 18,
    parameter logic [W-1:0]   MOD = '1
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum
);

    logic [W:0] s;
    logic       wrap;

    assign s    = {1'b0, a} + {1'b0, b};
    assign wrap = (s >= {1'b0, MOD});
    assign sum  = wrap ? W'(s - {1'b0, MOD}) : s[W-1:0];

endmodule

// File: rtl/rns_dot_accum8x18.sv
// Modular dot-product accumulator feeding the 8-digit RNS normalizer.
// Optional input range checking is enabled by defining RNS_ACC_RANGE_CHECK_EN.
module rns_dot_accum8x18
    import rns_pkg::*;
#(
    parameter int DATA_WIDTH = RNS_DIG_W,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  aclr_n,
    input  logic                  datavalid_in,
    input  logic                  last_in,
    input  logic [DATA_WIDTH-1:0] Prod_0_,
    input  logic [DATA_WIDTH-1:0] Prod_1_,
    input  logic [DATA_WIDTH-1:0] Prod_2_,
    input  logic [DATA_WIDTH-1:0] Prod_3_,
    input  logic [DATA_WIDTH-1:0] Prod_4_,
    input  logic [DATA_WIDTH-1:0] Prod_5_,
    input  logic [DATA_WIDTH-1:0] Prod_6_,
    input  logic [DATA_WIDTH-1:0] Prod_7_,
    output logic                  datavalid_out,
    output logic [DATA_WIDTH-1:0] Dig_0_,
    output logic [DATA_WIDTH-1:0] Dig_1_,
    output logic [DATA_WIDTH-1:0] Dig_2_,
    output logic [DATA_WIDTH-1:0] Dig_3_,
    output logic [DATA_WIDTH-1:0] Dig_4_,
    output logic [DATA_WIDTH-1:0] Dig_5_,
    output logic [DATA_WIDTH-1:0] Dig_6_,
    output logic [DATA_WIDTH-1:0] Dig_7_,
    output logic [CNT_WIDTH-1:0]  term_count,
    output logic                  err_range
);

    rns_vec_t             prod_in;
    rns_vec_t             prod_reg;
    logic                 valid_reg;
    logic                 last_reg;

    acc_state_t           state_reg, state_next;
    rns_vec_t             acc_reg,   acc_next;
    logic [CNT_WIDTH-1:0] cnt_reg,   cnt_next;
    rns_vec_t             dig_reg,   dig_next;
    logic [CNT_WIDTH-1:0] tc_reg,    tc_next;
    logic                 dv_reg,    dv_next;

    rns_vec_t             add_sum;
    rns_vec_t             sum_sel;
    logic [CNT_WIDTH-1:0] cnt_inc;
    logic                 first;

    assign prod_in = {Prod_7_, Prod_6_, Prod_5_, Prod_4_,
                      Prod_3_, Prod_2_, Prod_1_, Prod_0_};

    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            prod_reg  <= '0;
            valid_reg <= 1'b0;
            last_reg  <= 1'b0;
        end else begin
            prod_reg  <= prod_in;
            valid_reg <= datavalid_in;
            last_reg  <= datavalid_in & last_in;
        end
    end

    assign first = (state_reg == ACC_EMPTY);

    // An empty accumulator takes the incoming digit verbatim rather than 0 + p.
    for (genvar gi = 0; gi < RNS_NUM_DIG; gi++) begin : g_add
        rns_mod_add #(
            .W   (RNS_DIG_W),
            .MOD (RNS_MOD[gi])
        ) u_add (
            .a   (acc_reg[gi]),
            .b   (prod_reg[gi]),
            .sum (add_sum[gi])
        );
        assign sum_sel[gi] = first ? prod_reg[gi] : add_sum[gi];
    end

    assign cnt_inc = first      ? CNT_WIDTH'(1) :
                     (&cnt_reg) ? cnt_reg       : cnt_reg + CNT_WIDTH'(1);

    always_comb begin
        state_next = state_reg;
        acc_next   = acc_reg;
        cnt_next   = cnt_reg;
        dig_next   = dig_reg;
        tc_next    = tc_reg;
        dv_next    = 1'b0;
        if (valid_reg) begin
            if (last_reg) begin
                dig_next   = sum_sel;
                tc_next    = cnt_inc;
                dv_next    = 1'b1;
                acc_next   = '0;
                cnt_next   = '0;
                state_next = ACC_EMPTY;
            end else begin
                acc_next   = sum_sel;
                cnt_next   = cnt_inc;
                state_next = ACC_ACCUM;
            end
        end
    end

    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            state_reg <= ACC_EMPTY;
            acc_reg   <= '0;
            cnt_reg   <= '0;
            dig_reg   <= '0;
            tc_reg    <= '0;
            dv_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            acc_reg   <= acc_next;
            cnt_reg   <= cnt_next;
            dig_reg   <= dig_next;
            tc_reg    <= tc_next;
            dv_reg    <= dv_next;
        end
    end

`ifdef RNS_ACC_RANGE_CHECK_EN
    // p + 0 through the modular adder changes p exactly when p >= modulus.
    rns_vec_t                 rng_sum;
    logic [RNS_NUM_DIG-1:0]   range_hit;
    logic                     err_reg;

    for (genvar gi = 0; gi < RNS_NUM_DIG; gi++) begin : g_rng
        rns_mod_add #(
            .W   (RNS_DIG_W),
            .MOD (RNS_MOD[gi])
        ) u_rng (
            .a   (prod_in[gi]),
            .b   ({RNS_DIG_W{1'b0}}),
            .sum (rng_sum[gi])
        );
        assign range_hit[gi] = (rng_sum[gi] != prod_in[gi]);
    end

    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            err_reg <= 1'b0;
        end else if (datavalid_in && (|range_hit)) begin
            err_reg <= 1'b1;
        end
    end

    assign err_range = err_reg;
`else
    assign err_range = 1'b0;
`endif

    assign datavalid_out = dv_reg;
    assign term_count    = tc_reg;
    assign Dig_0_        = dig_reg[0];
    assign Dig_1_        = dig_reg[1];
    assign Dig_2_        = dig_reg[2];
    assign Dig_3_        = dig_reg[3];
    assign Dig_4_        = dig_reg[4];
    assign Dig_5_        = dig_reg[5];
    assign Dig_6_        = dig_reg[6];
    assign Dig_7_        = dig_reg[7];

endmodule

// File: tb/tb_rns_dot_accum8x18.sv
// Randomized bench for rns_dot_accum8x18 against a sum-then-reduce reference model.
module tb_rns_dot_accum8x18;

    localparam int CW = 16;
`ifdef RNS_ACC_RANGE_CHECK_EN
    localparam bit RANGE_EN = 1'b1;
`else
    localparam bit RANGE_EN = 1'b0;
`endif

    localparam int unsigned MODS [8] = '{262139, 262133, 262127, 262121,
                                         262111, 262109, 262103, 262079};

    typedef logic [7:0][17:0] vec_t;
    typedef struct packed {
        int            due;
        logic [CW-1:0] cnt;
        vec_t          dig;
    } exp_t;

    logic          clk = 1'b0;
    logic          aclr_n;
    logic          datavalid_in;
    logic          last_in;
    vec_t          prod_d;
    logic          datavalid_out;
    logic [17:0]   dig_o [8];
    logic [CW-1:0] term_count;
    logic          err_range;

    always #5 clk = ~clk;

    rns_dot_accum8x18 #(.DATA_WIDTH(18), .CNT_WIDTH(CW)) dut (
        .clk           (clk),
        .aclr_n        (aclr_n),
        .datavalid_in  (datavalid_in),
        .last_in       (last_in),
        .Prod_0_       (prod_d[0]),
        .Prod_1_       (prod_d[1]),
        .Prod_2_       (prod_d[2]),
        .Prod_3_       (prod_d[3]),
        .Prod_4_       (prod_d[4]),
        .Prod_5_       (prod_d[5]),
        .Prod_6_       (prod_d[6]),
        .Prod_7_       (prod_d[7]),
        .datavalid_out (datavalid_out),
        .Dig_0_        (dig_o[0]),
        .Dig_1_        (dig_o[1]),
        .Dig_2_        (dig_o[2]),
        .Dig_3_        (dig_o[3]),
        .Dig_4_        (dig_o[4]),
        .Dig_5_        (dig_o[5]),
        .Dig_6_        (dig_o[6]),
        .Dig_7_        (dig_o[7]),
        .term_count    (term_count),
        .err_range     (err_range)
    );

    int            checks = 0;
    int            errors = 0;
    int            cyc    = 0;
    exp_t          expq [$];
    longint unsigned part_sum [8];
    int            n_terms;
    vec_t          first_p;
    vec_t          held_dig;
    logic [CW-1:0] held_cnt;
    bit            exp_err;
    bit            err_arm;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic vec_t vec_all(input int unsigned x);
        vec_t v;
        for (int i = 0; i < 8; i++) v[i] = 18'(x);
        return v;
    endfunction

    function automatic vec_t rnd_vec();
        vec_t v;
        for (int i = 0; i < 8; i++) v[i] = 18'($urandom_range(MODS[i] - 1));
        return v;
    endfunction

    function automatic vec_t mod_minus1();
        vec_t v;
        for (int i = 0; i < 8; i++) v[i] = 18'(MODS[i] - 1);
        return v;
    endfunction

    function automatic void model_clear();
        n_terms = 0;
        for (int i = 0; i < 8; i++) part_sum[i] = 0;
    endfunction

    task automatic check_outputs();
        exp_t e;
        exp_err = exp_err | err_arm;
        err_arm = 1'b0;
        if (expq.size() > 0 && expq[0].due == cyc) begin
            e = expq.pop_front();
            check_val("pulse", 64'(datavalid_out), 64'd1);
            for (int i = 0; i < 8; i++)
                check_val($sformatf("dig%0d", i), 64'(dig_o[i]), 64'(e.dig[i]));
            check_val("term_count", 64'(term_count), 64'(e.cnt));
            held_dig = e.dig;
            held_cnt = e.cnt;
            $display("result cycle %0d term_count %0d dig0 %0h dig7 %0h",
                     cyc, term_count, dig_o[0], dig_o[7]);
        end else begin
            check_val("idle_pulse", 64'(datavalid_out), 64'd0);
            for (int i = 0; i < 8; i++)
                check_val($sformatf("hold_dig%0d", i), 64'(dig_o[i]), 64'(held_dig[i]));
            check_val("hold_count", 64'(term_count), 64'(held_cnt));
        end
        check_val("err_range", 64'(err_range), 64'(exp_err));
    endtask

    task automatic step(input bit rst, input bit v, input bit l, input vec_t p);
        exp_t e;
        @(negedge clk);
        cyc++;
        check_outputs();
        aclr_n       = !rst;
        datavalid_in = v;
        last_in      = l;
        prod_d       = p;
        if (rst) begin
            expq.delete();
            model_clear();
            held_dig = '0;
            held_cnt = '0;
            exp_err  = 1'b0;
            err_arm  = 1'b0;
        end else if (v) begin
            if (n_terms == 0) first_p = p;
            for (int i = 0; i < 8; i++) begin
                part_sum[i] += longint'(p[i]);
                if (RANGE_EN && p[i] >= MODS[i]) err_arm = 1'b1;
            end
            n_terms++;
            if (l) begin
                e.due = cyc + 2;
                e.cnt = (n_terms > 65535) ? 16'hFFFF : CW'(n_terms);
                for (int i = 0; i < 8; i++)
                    e.dig[i] = (n_terms == 1) ? first_p[i] : 18'(part_sum[i] % longint'(MODS[i]));
                expq.push_back(e);
                model_clear();
            end
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, rnd_vec());
    endtask

    initial begin
        vec_t p;
        aclr_n = 1'b0; datavalid_in = 1'b0; last_in = 1'b0; prod_d = '0;
        model_clear();
        held_dig = '0; held_cnt = '0; exp_err = 1'b0; err_arm = 1'b0;

        // Reset held with arbitrary toggling inputs
        for (int k = 0; k < 5; k++) begin
            p = {$urandom, $urandom, $urandom, $urandom, $urandom};
            step(1'b1, 1'($urandom), 1'($urandom), p);
        end
        step(1'b0, 1'b0, 1'b0, '0);

        // Single-term vector
        step(1'b0, 1'b1, 1'b1, vec_all(5));
        idle(4);

        // Wrap-around
        step(1'b0, 1'b1, 1'b0, mod_minus1());
        step(1'b0, 1'b1, 1'b1, vec_all(2));
        idle(3);

        // Back-to-back vectors with idle gaps inside the first
        step(1'b0, 1'b1, 1'b0, vec_all(1));
        idle(2);
        step(1'b0, 1'b1, 1'b0, vec_all(1));
        idle(2);
        step(1'b0, 1'b1, 1'b1, vec_all(1));
        step(1'b0, 1'b1, 1'b1, vec_all(7));
        idle(4);

        // Reset mid-vector
        step(1'b0, 1'b1, 1'b0, vec_all(9));
        step(1'b0, 1'b1, 1'b0, vec_all(9));
        step(1'b1, 1'b0, 1'b0, vec_all(9));
        step(1'b0, 1'b1, 1'b1, vec_all(4));
        idle(3);

        // Random traffic
        for (int k = 0; k < 400; k++)
            step(1'b0, $urandom_range(9) < 7, $urandom_range(3) == 0, rnd_vec());
        step(1'b0, 1'b1, 1'b1, rnd_vec());
        idle(3);

        // Out-of-range digit, then clean traffic, then reset
        p = rnd_vec();
        p[0] = 18'(MODS[0]);
        step(1'b0, 1'b1, 1'b1, p);
        for (int k = 0; k < 40; k++)
            step(1'b0, $urandom_range(9) < 7, $urandom_range(3) == 0, rnd_vec());
        step(1'b0, 1'b1, 1'b1, rnd_vec());
        idle(3);
        step(1'b1, 1'b0, 1'b0, '0);
        step(1'b0, 1'b0, 1'b0, '0);
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
